// File: rtl/seq_tester_pkg.sv
// Shared encodings, widths and tap positions for the sequential-circuit BIST driver.
// Pure declarations: no latency, no flow control.
package seq_tester_pkg;

  localparam int SIG_W  = 5;
  localparam int LFSR_W = 4;

  localparam int LFSR_TAP_HI = 3;
  localparam int LFSR_TAP_LO = 2;
  localparam int MISR_TAP_HI = 4;
  localparam int MISR_TAP_LO = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RESET_DUT = 2'd1,
    ST_RUN       = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
  endfunction

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? LFSR_W'(1) : s;
  endfunction

endpackage

// File: rtl/seq_circuit_tester_misr5.sv
// 5-bit MISR compacting the circuit outputs; updates one cycle after din is presented.
// No backpressure: en is a qualifier, clr has priority over en.
module misr5
  import seq_tester_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [SIG_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], sig[MISR_TAP_HI] ^ sig[MISR_TAP_LO]} ^ din;
    end
  end

endmodule

// File: rtl/seq_circuit_tester.sv
// BIST driver: resets the circuit, applies NUM_VECTORS LFSR A/B vectors, signs the outputs.
// Latency START->DONE is NUM_VECTORS+2 cycles; no backpressure, START ignored while busy.
module seq_circuit_tester
  import seq_tester_pkg::*;
#(
  parameter int                NUM_VECTORS = 16,
  parameter logic [LFSR_W-1:0] SEED        = 4'b1001,
  parameter logic [SIG_W-1:0]  EXP_SIG     = 5'b00000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic             DUT_RST,
  output logic             A,
  output logic             B,
  input  logic             Y,
  input  logic             Z,
  input  logic             X,
  input  logic             R,
  input  logic             S,
  output logic             BUSY,
  output logic             DONE,
  output logic [SIG_W-1:0] SIGNATURE,
  output logic             PASS
);

  localparam logic [7:0] LAST = 8'(NUM_VECTORS - 1);

  state_t            state;
  logic [LFSR_W-1:0] lfsr;
  logic [7:0]        count;

  // DUT_RST/BUSY/DONE are flops updated alongside each state transition.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      lfsr    <= seed_fix(SEED);
      count   <= '0;
      DUT_RST <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            state <= ST_RESET_DUT;
            BUSY  <= 1'b1;
          end
        end
        ST_RESET_DUT: begin
          lfsr    <= seed_fix(SEED);
          count   <= '0;
          state   <= ST_RUN;
          DUT_RST <= 1'b0;
        end
        ST_RUN: begin
          lfsr  <= lfsr_next(lfsr);
          count <= count + 8'd1;
          if (count == LAST) begin
            state <= ST_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (START) begin
            state   <= ST_RESET_DUT;
            DONE    <= 1'b0;
            BUSY    <= 1'b1;
            DUT_RST <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign A = (state == ST_RUN) & lfsr[0];
  assign B = (state == ST_RUN) & lfsr[1];

  misr5 u_misr (
    .clk (CLK),
    .rst (RST),
    .clr (state == ST_RESET_DUT),
    .en  (state == ST_RUN),
    .din ({Y, Z, X, R, S}),
    .sig (SIGNATURE)
  );

  assign PASS = DONE && (SIGNATURE == EXP_SIG);

endmodule
